fir_decim_framer: RTL
=====================

// Module: fir_decim_framer
// PURPOSE
//   Receive side of the FIR output interface (fir_data + single-cycle valid strobe, no backpressure).
//   Decimates the filtered beat signal by DECIM and scales/saturates 28-bit samples to OUT_WIDTH.
//   Buffers samples in a FIFO and emits them as a ready/valid stream framed per chirp
//   (m_last on the final sample of each chirp). Feeds the range-FFT stage.
// PARAMETERS
//   IN_WIDTH    28   signed FIR output width
//   OUT_WIDTH   16   signed output sample width
//   SHIFT       10   arithmetic right shift applied before saturation (>=1)
//   DECIM       4    keep 1 of every DECIM valid input samples (>=1)
//   FRAME_LEN   256  kept samples per chirp frame (>=2)
//   FIFO_DEPTH  16   output FIFO entries, power of 2
// PORTS
//   clk          in   1          clock
//   rst_n        in   1          asynchronous reset, active-low
//   chirp_start  in   1          1-cycle pulse: new chirp begins
//   fir_data     in   IN_WIDTH   signed filtered sample
//   fir_valid    in   1          fir_data valid this cycle
//   m_data       out  OUT_WIDTH  signed output sample
//   m_valid      out  1          m_data/m_last valid
//   m_ready      in   1          downstream accepts when m_valid & m_ready
//   m_last       out  1          last sample of frame
//   frame_short  out  1          1-cycle pulse: chirp_start arrived mid-frame
//   overflow     out  1          sticky: a kept sample was dropped on full FIFO
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, FIFO empty, phase=0, sample count=0.
//   States: IDLE -> RUN on chirp_start; stays RUN until reset. In IDLE all fir_valid is discarded.
//   Phase counter 0..DECIM-1 advances on each fir_valid in RUN, wraps; sample kept when phase==0.
//   chirp_start forces phase=0 and count=0 in the same cycle; a fir_valid coincident with
//     chirp_start is kept as sample 0 of the new frame (applies to IDLE->RUN as well).
//   chirp_start with count!=0 in RUN: frame_short=1 next cycle; queued partial-frame samples
//     are emitted unchanged (no m_last inserted); the FIFO is not flushed.
//   Scaling: y = fir_data >>> SHIFT; saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//   Count 0..FRAME_LEN-1 advances per kept sample; sample at count FRAME_LEN-1 carries last=1;
//     count then wraps to 0.
//   Pipeline: kept sample is registered (scale stage) 1 cycle, then written to FIFO;
//     m_valid rises at the earliest 2 cycles after the kept fir_valid.
//   FIFO full at write: sample dropped, overflow set, count still advances (frame alignment kept).
//     Full and read in the same cycle: write accepted, no drop.
//   Output is first-word-fall-through; m_data/m_last held stable while m_valid & !m_ready.
//     Empty: m_valid=0, m_data/m_last hold their last values.
//   Reset mid-operation: immediate clear of FIFO, counters, flags; returns to IDLE.
// CONFIGURATION
//   FIR_DECIM_ROUND_EN defined: add 2^(SHIFT-1) to fir_data (computed in IN_WIDTH+1 bits)
//     before the shift (round half up), then saturate.
//   Not defined: plain truncating arithmetic shift, then saturate.
// TESTING
//   DECIM=4, chirp_start, then 8 fir_valid with data k<<10 (k=0..7), m_ready=1
//     -> m_data 0,4 out; first m_valid 2 cycles after first fir_valid.
//   fir_data=28'h7FFFFFF / 28'h8000000 -> m_data=16'h7FFF / 16'h8000.
//   fir_data=1536 (1.5<<10) -> 1 without FIR_DECIM_ROUND_EN; 2 with it. -1536 -> -2 / -1.
//   FRAME_LEN=4, DECIM=1, 9 samples -> m_last on the 4th and 8th outputs only.
//   m_ready=0, 20 kept samples, FIFO_DEPTH=16 -> 16 held, overflow=1; after drain the next
//     frame's m_last position is unchanged.
//   chirp_start after 2 kept samples -> frame_short pulse; next frame's m_last at its own 4th sample.

Source files
------------

// File: rtl/fir_decim_framer.sv
// Decimating, scaling and saturating receiver for the FIR output. Kept samples are framed per chirp
// and emitted through a first-word-fall-through FIFO. Define FIR_DECIM_ROUND_EN for round-half-up scaling.
module fir_decim_framer #(
  parameter int IN_WIDTH   = 28,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 10,
  parameter int DECIM      = 4,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        chirp_start,
  input  logic signed [IN_WIDTH-1:0]  fir_data,
  input  logic                        fir_valid,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        frame_short,
  output logic                        overflow
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'((2 ** (OUT_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_reg, state_next;
  logic                    run_active;
  logic [PH_W-1:0]         phase_reg, phase_next, ph_base;
  logic [CNT_W-1:0]        count_reg, count_next, cnt_base;
  logic                    accept, keep, keep_last, short_next;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (chirp_start) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    run_active = (state_reg == RUN);
  end

  // chirp_start restarts phase and count in the same cycle, so a coincident sample becomes sample 0
  always_comb begin
    ph_base    = chirp_start ? '0 : phase_reg;
    cnt_base   = chirp_start ? '0 : count_reg;
    accept     = fir_valid && (run_active || chirp_start);
    keep       = accept && (ph_base == '0);
    keep_last  = (cnt_base == CNT_W'(FRAME_LEN - 1));
    short_next = chirp_start && run_active && (count_reg != '0);
    phase_next = ph_base;
    if (accept)
      phase_next = (ph_base == PH_W'(DECIM - 1)) ? '0 : ph_base + 1'b1;
    count_next = cnt_base;
    if (keep)
      count_next = keep_last ? '0 : cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg   <= '0;
      count_reg   <= '0;
      frame_short <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      count_reg   <= count_next;
      frame_short <= short_next;
    end
  end

  // ---------------- scaling ----------------
  logic signed [IN_WIDTH:0]    ext, shifted;
  logic signed [OUT_WIDTH-1:0] scaled;

  assign ext = {fir_data[IN_WIDTH-1], fir_data};
`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [IN_WIDTH:0] RND = (IN_WIDTH+1)'(2 ** (SHIFT-1));
  assign shifted = (ext + RND) >>> SHIFT;
`else
  assign shifted = ext >>> SHIFT;
`endif

  always_comb begin
    if (shifted > SAT_MAX)      scaled = SAT_MAX[OUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) scaled = SAT_MIN[OUT_WIDTH-1:0];
    else                        scaled = shifted[OUT_WIDTH-1:0];
  end

  logic                 s_valid_reg, s_last_reg;
  logic [OUT_WIDTH-1:0] s_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_reg <= 1'b0;
      s_last_reg  <= 1'b0;
      s_data_reg  <= '0;
    end else begin
      s_valid_reg <= keep;
      if (keep) begin
        s_last_reg <= keep_last;
        s_data_reg <= scaled;
      end
    end
  end

  // ---------------- output FIFO (first-word-fall-through) ----------------
  logic [OUT_WIDTH:0]   mem [FIFO_DEPTH];
  logic [OUT_WIDTH:0]   head;
  logic [AW:0]          wr_ptr_reg, rd_ptr_reg;
  logic                 fifo_empty, fifo_full, push, pop, drop;
  logic [OUT_WIDTH-1:0] hold_data_reg;
  logic                 hold_last_reg;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head       = mem[rd_ptr_reg[AW-1:0]];
  assign m_valid    = !fifo_empty;
  assign pop        = m_valid && m_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write
  assign push       = s_valid_reg && (!fifo_full || pop);
  assign drop       = s_valid_reg && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {s_last_reg, s_data_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow      <= 1'b0;
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        hold_data_reg <= head[OUT_WIDTH-1:0];
        hold_last_reg <= head[OUT_WIDTH];
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // When empty, the most recently delivered word stays on the bus
  assign m_data = fifo_empty ? hold_data_reg : head[OUT_WIDTH-1:0];
  assign m_last = fifo_empty ? hold_last_reg : head[OUT_WIDTH];

endmodule
